// File: rtl/noc_router_pkg.sv
// Shared definitions for the forwarding-unit merge arbiters: grant encodings,
// default packet width and the debug view of arbiter state.
package noc_router_pkg;

  localparam logic [1:0] GRANT_A    = 2'd0;
  localparam logic [1:0] GRANT_B    = 2'd1;
  localparam logic [1:0] GRANT_C    = 2'd2;
  localparam logic [1:0] GRANT_NONE = 2'd3;

  localparam int PACKET_WIDTH = 21;

  // burst_cnt is zero-extended to 8 bits, enough for any legal burst limit.
  typedef struct packed {
    logic [1:0] last_owner;
    logic       owner_valid;
    logic [7:0] burst_cnt;
  } arb_dbg_t;

endpackage

// File: rtl/merge3_rr_arbiter_if.sv
// Three-input merge bus: FWFT input FIFO heads and flags on one side,
// pop strobes and the forwarded word toward the path decoder on the other.
interface merge3_rr_arbiter_if #(
  parameter int DATA_WIDTH = 21
);
  // Handshake: a head word din_x is consumed when read_en_x is high at a rising
  // clk edge (only ever while buffer_x_empty=0); dout is valid exactly when wen=1,
  // and buffer_out_full=1 blocks every pop and write in that cycle.
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] din_c;
  logic                  buffer_a_empty;
  logic                  buffer_b_empty;
  logic                  buffer_c_empty;
  logic                  buffer_out_full;
  logic                  read_en_a;
  logic                  read_en_b;
  logic                  read_en_c;
  logic [DATA_WIDTH-1:0] dout;
  logic                  wen;
  logic [1:0]            grant_id;

  modport master (
    input  din_a, din_b, din_c,
    input  buffer_a_empty, buffer_b_empty, buffer_c_empty, buffer_out_full,
    output read_en_a, read_en_b, read_en_c, dout, wen, grant_id
  );

  modport slave (
    output din_a, din_b, din_c,
    output buffer_a_empty, buffer_b_empty, buffer_c_empty, buffer_out_full,
    input  read_en_a, read_en_b, read_en_c, dout, wen, grant_id
  );
endinterface

// File: rtl/rr_pick3.sv
// Combinational 3-way round-robin pick: searches last_owner+1, +2, +3 (mod 3)
// and returns the first requester, so the previous owner is checked last.
module rr_pick3
  import noc_router_pkg::*;
(
  input  logic [2:0] request,
  input  logic [1:0] last_owner,
  output logic [1:0] winner,
  output logic       found
);

  logic [1:0] first, second, third;

  always_comb begin
    first  = GRANT_A;
    second = GRANT_B;
    third  = GRANT_C;
    case (last_owner)
      GRANT_A: begin first = GRANT_B; second = GRANT_C; third = GRANT_A; end
      GRANT_B: begin first = GRANT_C; second = GRANT_A; third = GRANT_B; end
      default: begin first = GRANT_A; second = GRANT_B; third = GRANT_C; end
    endcase
  end

  always_comb begin
    winner = GRANT_NONE;
    found  = 1'b0;
    if (request[first]) begin
      winner = first;
      found  = 1'b1;
    end else if (request[second]) begin
      winner = second;
      found  = 1'b1;
    end else if (request[third]) begin
      winner = third;
      found  = 1'b1;
    end
  end

endmodule

// File: rtl/merge3_rr_arbiter.sv
// Burst-limited round-robin merge of three FWFT FIFOs into one output path.
// Optional ARB_STALL_CNT_EN adds a saturating downstream-stall cycle counter.
module merge3_rr_arbiter
  import noc_router_pkg::*;
#(
  parameter int DATA_WIDTH = PACKET_WIDTH,
  parameter int MAX_BURST  = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  merge3_rr_arbiter_if.master       bus,
  output arb_dbg_t                  dbg_state
`ifdef ARB_STALL_CNT_EN
  ,
  input  logic                      stall_clr,
  output logic [15:0]               stall_cycles
`endif
);

  localparam int             CW    = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAX_B = CW'(MAX_BURST);

  logic [1:0]    last_owner, last_owner_nxt;
  logic          owner_valid, owner_valid_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;

  logic [2:0]    request;
  logic [1:0]    pick_winner;
  logic          pick_found;
  logic          hold;
  logic [1:0]    grant;
  logic [1:0]    grant_live;

  assign request = {~bus.buffer_c_empty, ~bus.buffer_b_empty, ~bus.buffer_a_empty};

  rr_pick3 u_pick (
    .request    (request),
    .last_owner (last_owner),
    .winner     (pick_winner),
    .found      (pick_found)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_owner  <= GRANT_C;
      owner_valid <= 1'b0;
      burst_cnt   <= '0;
    end else begin
      last_owner  <= last_owner_nxt;
      owner_valid <= owner_valid_nxt;
      burst_cnt   <= burst_cnt_nxt;
    end
  end

  assign hold = owner_valid && request[last_owner] && (burst_cnt < MAX_B);

  // A full downstream freezes the burst rather than releasing it.
  always_comb begin
    last_owner_nxt  = last_owner;
    owner_valid_nxt = owner_valid;
    burst_cnt_nxt   = burst_cnt;
    grant           = GRANT_NONE;
    if (!bus.buffer_out_full) begin
      if (hold) begin
        grant         = last_owner;
        burst_cnt_nxt = burst_cnt + CW'(1);
      end else if (pick_found) begin
        grant           = pick_winner;
        last_owner_nxt  = pick_winner;
        owner_valid_nxt = 1'b1;
        burst_cnt_nxt   = CW'(1);
      end else begin
        owner_valid_nxt = 1'b0;
        burst_cnt_nxt   = '0;
      end
    end
  end

  // Outputs are masked by reset_n so they drop the instant reset asserts.
  assign grant_live = reset_n ? grant : GRANT_NONE;

  always_comb begin
    bus.read_en_a = (grant_live == GRANT_A);
    bus.read_en_b = (grant_live == GRANT_B);
    bus.read_en_c = (grant_live == GRANT_C);
    bus.wen       = (grant_live != GRANT_NONE);
    bus.grant_id  = grant_live;
    case (grant_live)
      GRANT_A: bus.dout = bus.din_a;
      GRANT_B: bus.dout = bus.din_b;
      GRANT_C: bus.dout = bus.din_c;
      default: bus.dout = '0;
    endcase
  end

  always_comb begin
    dbg_state.last_owner  = last_owner;
    dbg_state.owner_valid = owner_valid;
    dbg_state.burst_cnt   = 8'(burst_cnt);
  end

`ifdef ARB_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (stall_clr) begin
      stall_cycles <= '0;
    end else if (bus.buffer_out_full && (|request) && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_merge3_rr_arbiter.sv
// Directed bench for merge3_rr_arbiter: dut0 uses MAX_BURST=4, dut1 MAX_BURST=1;
// both see the same FIFO model, which follows whichever DUT a step targets.
module tb_merge3_rr_arbiter;
  import noc_router_pkg::*;

  localparam int W = 21;

  logic clk;
  logic reset_n;

  logic [W-1:0] din_a, din_b, din_c;
  logic a_empty, b_empty, c_empty, out_full;

  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] qc[$];
  logic [1:0]   exp_q[$];

  int checks;
  int errors;

  arb_dbg_t dbg0, dbg1;

  merge3_rr_arbiter_if #(.DATA_WIDTH(W)) bus0 ();
  merge3_rr_arbiter_if #(.DATA_WIDTH(W)) bus1 ();

  assign bus0.din_a = din_a;  assign bus1.din_a = din_a;
  assign bus0.din_b = din_b;  assign bus1.din_b = din_b;
  assign bus0.din_c = din_c;  assign bus1.din_c = din_c;
  assign bus0.buffer_a_empty  = a_empty;  assign bus1.buffer_a_empty  = a_empty;
  assign bus0.buffer_b_empty  = b_empty;  assign bus1.buffer_b_empty  = b_empty;
  assign bus0.buffer_c_empty  = c_empty;  assign bus1.buffer_c_empty  = c_empty;
  assign bus0.buffer_out_full = out_full; assign bus1.buffer_out_full = out_full;

`ifdef ARB_STALL_CNT_EN
  logic        stall_clr;
  logic [15:0] stall0, stall1;
`endif

  merge3_rr_arbiter #(.DATA_WIDTH(W), .MAX_BURST(4)) dut0 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus0),
    .dbg_state (dbg0)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_clr    (stall_clr),
    .stall_cycles (stall0)
`endif
  );

  merge3_rr_arbiter #(.DATA_WIDTH(W), .MAX_BURST(1)) dut1 (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus1),
    .dbg_state (dbg1)
`ifdef ARB_STALL_CNT_EN
    ,
    .stall_clr    (stall_clr),
    .stall_cycles (stall1)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int id, input int i);
    return W'(((id + 1) << 16) | i);
  endfunction

  function automatic logic [W-1:0] head(input logic [1:0] g);
    logic [W-1:0] v;
    v = '0;
    case (g)
      GRANT_A: if (qa.size() > 0) v = qa[0];
      GRANT_B: if (qb.size() > 0) v = qb[0];
      GRANT_C: if (qc.size() > 0) v = qc[0];
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic drive_inputs();
    din_a   = (qa.size() > 0) ? qa[0] : '0;
    din_b   = (qb.size() > 0) ? qb[0] : '0;
    din_c   = (qc.size() > 0) ? qc[0] : '0;
    a_empty = (qa.size() == 0);
    b_empty = (qb.size() == 0);
    c_empty = (qc.size() == 0);
  endtask

  task automatic load(input int na, input int nb, input int nc);
    for (int i = 0; i < na; i++) qa.push_back(mk(0, i));
    for (int i = 0; i < nb; i++) qb.push_back(mk(1, i));
    for (int i = 0; i < nc; i++) qc.push_back(mk(2, i));
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    out_full = 1'b0;
    qa.delete(); qb.delete(); qc.delete(); exp_q.delete();
    drive_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One cycle: check outputs of the selected DUT against exp_g, then pop the model.
  task automatic step(input int sel, input logic [1:0] exp_g, input string tag);
    logic [1:0]   g;
    logic         w;
    logic [2:0]   re;
    logic [W-1:0] d;
    logic [2:0]   exp_re;
    logic [W-1:0] exp_d;
    drive_inputs();
    @(negedge clk);
    if (sel == 0) begin
      g = bus0.grant_id; w = bus0.wen; d = bus0.dout;
      re = {bus0.read_en_c, bus0.read_en_b, bus0.read_en_a};
    end else begin
      g = bus1.grant_id; w = bus1.wen; d = bus1.dout;
      re = {bus1.read_en_c, bus1.read_en_b, bus1.read_en_a};
    end
    exp_re = 3'b000;
    exp_d  = '0;
    if (exp_g != GRANT_NONE) begin
      exp_re[exp_g] = 1'b1;
      exp_d = head(exp_g);
    end
    checks++;
    if (g !== exp_g) begin
      errors++;
      $display("FAIL %s grant_id got %0d want %0d at %0t", tag, g, exp_g, $time);
    end
    checks++;
    if (w !== (exp_g != GRANT_NONE)) begin
      errors++;
      $display("FAIL %s wen got %b want %b at %0t", tag, w, exp_g != GRANT_NONE, $time);
    end
    checks++;
    if (re !== exp_re) begin
      errors++;
      $display("FAIL %s read_en got %b want %b at %0t", tag, re, exp_re, $time);
    end
    checks++;
    if (d !== exp_d) begin
      errors++;
      $display("FAIL %s dout got %h want %h at %0t", tag, d, exp_d, $time);
    end
    checks++;
    if ((re & ({c_empty, b_empty, a_empty} | {3{out_full}})) !== 3'b000) begin
      errors++;
      $display("FAIL %s read_en on empty/full got %b at %0t", tag, re, $time);
    end
    @(posedge clk);
    #1;
    case (exp_g)
      GRANT_A: void'(qa.pop_front());
      GRANT_B: void'(qb.pop_front());
      GRANT_C: void'(qc.pop_front());
      default: ;
    endcase
  endtask

  task automatic run_exp(input int sel, input string tag);
    while (exp_q.size() > 0) step(sel, exp_q.pop_front(), tag);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    out_full = 1'b0;
    qa.delete(); qb.delete(); qc.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 5) load(1, 1, 1);
      drive_inputs();
      @(negedge clk);
      checks++;
      if (bus0.grant_id !== GRANT_NONE || bus0.wen !== 1'b0 || bus0.dout !== '0 ||
          {bus0.read_en_c, bus0.read_en_b, bus0.read_en_a} !== 3'b000) begin
        errors++;
        $display("FAIL reset_outputs grant %0d wen %b want 3/0 cycle %0d", bus0.grant_id, bus0.wen, i);
      end
    end
    qa.delete(); qb.delete(); qc.delete();
    drive_inputs();
    checks++;
    if (dbg0.last_owner !== GRANT_C || dbg0.owner_valid !== 1'b0 || dbg0.burst_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state got %0d/%b/%0d want 2/0/0", dbg0.last_owner, dbg0.owner_valid, dbg0.burst_cnt);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    checks++;
    if (bus0.wen !== 1'b0) begin
      errors++;
      $display("FAIL reset_release wen got %b want 0", bus0.wen);
    end
    repeat (3) step(0, GRANT_NONE, "idle_after_reset");
  endtask

  task automatic test_burst_rotation();
    do_reset();
    load(8, 8, 8);
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 3; g++)
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(g));
    run_exp(0, "burst_rotation");
    step(0, GRANT_NONE, "burst_drained");
  endtask

  task automatic test_single_input();
    do_reset();
    load(0, 6, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, GRANT_B, "single_b");
      checks++;
      if (dbg0.burst_cnt !== 8'((i % 4) + 1)) begin
        errors++;
        $display("FAIL single_b burst_cnt got %0d want %0d", dbg0.burst_cnt, (i % 4) + 1);
      end
    end
    step(0, GRANT_NONE, "single_b_empty");
    checks++;
    if (dbg0.owner_valid !== 1'b0 || dbg0.burst_cnt !== 8'd0 || dbg0.last_owner !== GRANT_B) begin
      errors++;
      $display("FAIL idle_release got %0d/%b/%0d want 1/0/0", dbg0.last_owner, dbg0.owner_valid, dbg0.burst_cnt);
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    load(4, 2, 0);
    step(0, GRANT_A, "pre_stall");
    step(0, GRANT_A, "pre_stall");
    out_full = 1'b1;
    repeat (3) step(0, GRANT_NONE, "stall");
    checks++;
    if (dbg0.burst_cnt !== 8'd2 || dbg0.last_owner !== GRANT_A || dbg0.owner_valid !== 1'b1) begin
      errors++;
      $display("FAIL stall_frozen got %0d/%b/%0d want 0/1/2", dbg0.last_owner, dbg0.owner_valid, dbg0.burst_cnt);
    end
    out_full = 1'b0;
    exp_q = '{GRANT_A, GRANT_A, GRANT_B, GRANT_B, GRANT_NONE};
    run_exp(0, "post_stall");
  endtask

  task automatic test_early_release();
    do_reset();
    load(1, 2, 2);
    exp_q = '{GRANT_A, GRANT_B, GRANT_B, GRANT_C, GRANT_C, GRANT_NONE};
    run_exp(0, "early_release");
    do_reset();
    load(2, 2, 2);
    exp_q = '{GRANT_A, GRANT_B, GRANT_C, GRANT_A, GRANT_B, GRANT_C, GRANT_NONE};
    run_exp(1, "burst1_rr");
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    load(4, 0, 0);
    step(0, GRANT_A, "mid_burst");
    step(0, GRANT_A, "mid_burst");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus0.wen !== 1'b0 || bus0.grant_id !== GRANT_NONE || bus0.read_en_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs wen %b grant %0d want 0/3", bus0.wen, bus0.grant_id);
    end
    checks++;
    if (dbg0.last_owner !== GRANT_C || dbg0.owner_valid !== 1'b0 || dbg0.burst_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset_state got %0d/%b/%0d want 2/0/0", dbg0.last_owner, dbg0.owner_valid, dbg0.burst_cnt);
    end
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_q = '{GRANT_A, GRANT_A, GRANT_NONE};
    run_exp(0, "after_mid_reset");
  endtask

`ifdef ARB_STALL_CNT_EN
  task automatic test_stall_counter();
    do_reset();
    load(1, 0, 0);
    out_full = 1'b1;
    step(0, GRANT_NONE, "stall_cnt_full");
    repeat (70000) @(posedge clk);
    #1;
    checks++;
    if (stall0 !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate got %h want ffff", stall0);
    end
    stall_clr = 1'b1;
    @(posedge clk);
    #1 stall_clr = 1'b0;
    checks++;
    if (stall0 !== 16'h0000) begin
      errors++;
      $display("FAIL stall_clear got %h want 0000", stall0);
    end
    out_full = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    out_full = 1'b0;
`ifdef ARB_STALL_CNT_EN
    stall_clr = 1'b0;
`endif
    drive_inputs();
    test_reset();
    test_burst_rotation();
    test_single_input();
    test_full_stall();
    test_early_release();
    test_reset_mid_burst();
`ifdef ARB_STALL_CNT_EN
    test_stall_counter();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
